// File: rtl/race_physics_core.sv
// race_physics_core: one car's heading/speed/position integration, collision response and lap tracking.
// Define RPC_BOOST_EN to make colour 2 a boost surface; undefined, colour 2 is ordinary track.
module race_physics_core #(
  parameter int unsigned START_X      = 0,
  parameter int unsigned START_Y      = 120,
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned TICK_HZ      = 120,
  parameter int unsigned FRAC_BITS    = 10,
  parameter int unsigned MAX_FWD      = 12,
  parameter int unsigned MAX_REV      = 8,
  parameter int unsigned SLOW_FWD     = 6,
  parameter int unsigned SLOW_REV     = 4,
  parameter int unsigned MAP_W        = 640,
  parameter int unsigned MAP_H        = 480,
  parameter int unsigned WALL_MARGIN  = 6,
  parameter int unsigned COLLISION_R2 = 144,
  parameter int unsigned HIT_CD       = 30,
  parameter int unsigned WALL_CD      = 20,
  parameter int unsigned NUM_CKPT     = 4,
  parameter int unsigned NUM_LAPS     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    state,
  input  logic [1:0]                    h_code,
  input  logic [1:0]                    v_code,
  input  logic [1:0]                    color,
  input  logic [40*NUM_CKPT-1:0]        ckpt_box,
  input  logic [9:0]                    other_f_x,
  input  logic [9:0]                    other_f_y,
  input  logic [9:0]                    other_r_x,
  input  logic [9:0]                    other_r_y,
  output logic [9:0]                    my_f_x,
  output logic [9:0]                    my_f_y,
  output logic [9:0]                    my_r_x,
  output logic [9:0]                    my_r_y,
  output logic [9:0]                    pos_x,
  output logic [9:0]                    pos_y,
  output logic [3:0]                    angle_idx,
  output logic signed [9:0]             speed_out,
  output logic [$clog2(NUM_CKPT):0]     ckpt_idx,
  output logic [$clog2(NUM_LAPS):0]     lap,
  output logic                          finish,
  output logic                          tick
);
  localparam int unsigned AW     = 10 + FRAC_BITS;
  localparam int unsigned TERM   = CLK_FREQ / TICK_HZ;
  localparam int unsigned CW     = (TERM < 2) ? 1 : $clog2(TERM + 1);
  localparam int unsigned CKW    = $clog2(NUM_CKPT) + 1;
  localparam int unsigned LPW    = $clog2(NUM_LAPS) + 1;
  localparam int unsigned CD_MAX = (HIT_CD > WALL_CD) ? HIT_CD : WALL_CD;
  localparam int unsigned CDW    = $clog2(CD_MAX + 1);
  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_RACING = 3'd4;
  localparam logic signed [9:0] FWD_LIM  = 10'(MAX_FWD);
  localparam logic signed [9:0] REV_LIM  = -(10'(MAX_REV));
  localparam logic signed [9:0] SLOW_HI  = 10'(SLOW_FWD);
  localparam logic signed [9:0] SLOW_LO  = -(10'(SLOW_REV));
`ifdef RPC_BOOST_EN
  localparam logic signed [9:0] BOOST_LIM = 10'(MAX_FWD + 4);
`endif

  logic [CW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                tick_q, tick_d;
  logic [AW-1:0]       accum_x_q, accum_x_d, accum_y_q, accum_y_d;
  logic [9:0]          pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [9:0]   speed_q, speed_d, speed_out_q, speed_out_d;
  logic [5:0]          angle_q, angle_d;
  logic [3:0]          angle_idx_q, angle_idx_d;
  logic [1:0]          turn_delay_q, turn_delay_d;
  logic [2:0]          speed_delay_q, speed_delay_d;
  logic [CDW-1:0]      cooldown_q, cooldown_d;
  logic [CKW-1:0]      ckpt_q, ckpt_d;
  logic [LPW-1:0]      lap_q, lap_d;
  logic                finish_q, finish_d;
  logic [3:0]          hit_q, hit_d;
  logic [9:0]          f_x_q, f_x_d, f_y_q, f_y_d, r_x_q, r_x_d, r_y_q, r_y_d;

  logic signed [9:0]   dir_x_c, dir_y_c, target_c, lim_fwd_c;
  logic signed [19:0]  mul_x_c, mul_y_c;
  logic [39:0]         box_c;
  logic                accel_now_c, upd_c, wall_f_c, wall_r_c, inside_c;

  function automatic logic [9:0] round_pos(input logic [AW-1:0] a);
    return a[AW-1:FRAC_BITS] + 10'(a[FRAC_BITS-1]);
  endfunction

  function automatic logic signed [9:0] step_toward(input logic signed [9:0] s,
                                                    input logic signed [9:0] lim);
    if (s < lim) return s + 10'sd1;
    if (s > lim) return s - 10'sd1;
    return s;
  endfunction

  // Squared-distance proximity test between two centres.
  function automatic logic near(input logic [9:0] ax, input logic [9:0] ay,
                                input logic [9:0] bx, input logic [9:0] by);
    logic signed [10:0] dx, dy;
    logic [10:0]        mx, my;
    logic [21:0]        sum;
    dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
    mx  = dx[10] ? 11'(-dx) : 11'(dx);
    my  = dy[10] ? 11'(-dy) : 11'(dy);
    sum = 22'(mx) * 22'(mx) + 22'(my) * 22'(my);
    return sum < 22'(COLLISION_R2);
  endfunction

  // Heading unit vector, magnitude 256, screen y grows downward.
  always_comb begin
    dir_x_c = 10'sd0;
    dir_y_c = 10'sd0;
    case (angle_q[5:2])
      4'd0:  begin dir_x_c =  10'sd0;   dir_y_c = -10'sd256; end
      4'd1:  begin dir_x_c =  10'sd100; dir_y_c = -10'sd236; end
      4'd2:  begin dir_x_c =  10'sd181; dir_y_c = -10'sd181; end
      4'd3:  begin dir_x_c =  10'sd236; dir_y_c = -10'sd100; end
      4'd4:  begin dir_x_c =  10'sd256; dir_y_c =  10'sd0;   end
      4'd5:  begin dir_x_c =  10'sd236; dir_y_c =  10'sd100; end
      4'd6:  begin dir_x_c =  10'sd181; dir_y_c =  10'sd181; end
      4'd7:  begin dir_x_c =  10'sd100; dir_y_c =  10'sd236; end
      4'd8:  begin dir_x_c =  10'sd0;   dir_y_c =  10'sd256; end
      4'd9:  begin dir_x_c = -10'sd100; dir_y_c =  10'sd236; end
      4'd10: begin dir_x_c = -10'sd181; dir_y_c =  10'sd181; end
      4'd11: begin dir_x_c = -10'sd236; dir_y_c =  10'sd100; end
      4'd12: begin dir_x_c = -10'sd256; dir_y_c =  10'sd0;   end
      4'd13: begin dir_x_c = -10'sd236; dir_y_c = -10'sd100; end
      4'd14: begin dir_x_c = -10'sd181; dir_y_c = -10'sd181; end
      default: begin dir_x_c = -10'sd100; dir_y_c = -10'sd236; end
    endcase
  end

  // Target speed from throttle, surface and acceleration pacing.
  always_comb begin
    lim_fwd_c   = FWD_LIM;
    accel_now_c = (speed_delay_q == 3'd0);
`ifdef RPC_BOOST_EN
    if (color == 2'd2) begin
      lim_fwd_c = BOOST_LIM;
      if (v_code == 2'd1) accel_now_c = 1'b1;
    end
`endif
    target_c = speed_q;
    if (accel_now_c) begin
      if (v_code == 2'd1)      target_c = step_toward(speed_q, lim_fwd_c);
      else if (v_code == 2'd2) target_c = step_toward(speed_q, REV_LIM);
      else                     target_c = step_toward(speed_q, 10'sd0);
    end
    if (color == 2'd3) begin
      if (target_c > SLOW_HI) target_c = SLOW_HI;
      if (target_c < SLOW_LO) target_c = SLOW_LO;
    end
  end

  always_comb begin
    box_c = '0;
    for (int unsigned k = 0; k < NUM_CKPT; k++) begin
      if (ckpt_q == CKW'(k)) box_c = ckpt_box[40*k +: 40];
    end
  end

  assign mul_x_c  = 20'(speed_q) * 20'(dir_x_c);
  assign mul_y_c  = 20'(speed_q) * 20'(dir_y_c);
  assign upd_c    = tick_q && (state == ST_RACING) && !finish_q;
  assign wall_f_c = (f_x_q < 10'(WALL_MARGIN)) || (f_x_q > 10'(MAP_W - WALL_MARGIN)) ||
                    (f_y_q < 10'(WALL_MARGIN)) || (f_y_q > 10'(MAP_H - WALL_MARGIN));
  assign wall_r_c = (r_x_q < 10'(WALL_MARGIN)) || (r_x_q > 10'(MAP_W - WALL_MARGIN)) ||
                    (r_y_q < 10'(WALL_MARGIN)) || (r_y_q > 10'(MAP_H - WALL_MARGIN));
  assign inside_c = (f_x_q > box_c[39:30]) && (f_x_q < box_c[29:20]) &&
                    (f_y_q > box_c[19:10]) && (f_y_q < box_c[9:0]);

  // Next-state: tick counter, steering, motion priority, checkpoints, IDLE init.
  always_comb begin
    tick_cnt_d    = (tick_cnt_q == CW'(TERM)) ? '0 : tick_cnt_q + CW'(1);
    tick_d        = (tick_cnt_q == CW'(TERM));
    accum_x_d     = accum_x_q;
    accum_y_d     = accum_y_q;
    speed_d       = speed_q;
    speed_out_d   = speed_q;
    angle_d       = angle_q;
    angle_idx_d   = angle_idx_q;
    turn_delay_d  = turn_delay_q;
    speed_delay_d = speed_delay_q;
    cooldown_d    = cooldown_q;
    ckpt_d        = ckpt_q;
    lap_d         = lap_q;
    finish_d      = finish_q;
    hit_d         = hit_q;

    if (upd_c) begin
      angle_idx_d = angle_q[5:2];
      if (h_code == 2'd1 || h_code == 2'd2) begin
        if (turn_delay_q == 2'd0) begin
          angle_d      = (h_code == 2'd1) ? angle_q - 6'd1 : angle_q + 6'd1;
          turn_delay_d = 2'd2;
        end else begin
          turn_delay_d = turn_delay_q - 2'd1;
        end
      end else begin
        turn_delay_d = 2'd0;
      end

      hit_d = {near(f_x_q, f_y_q, other_f_x, other_f_y), near(f_x_q, f_y_q, other_r_x, other_r_y),
               near(r_x_q, r_y_q, other_f_x, other_f_y), near(r_x_q, r_y_q, other_r_x, other_r_y)};

      if (cooldown_q != '0 || !((|hit_q) || wall_f_c || wall_r_c)) begin
        if (cooldown_q != '0) cooldown_d = cooldown_q - CDW'(1);
        accum_x_d     = accum_x_q + AW'(mul_x_c >>> 2);
        accum_y_d     = accum_y_q + AW'(mul_y_c >>> 2);
        speed_d       = target_c;
        speed_delay_d = speed_delay_q + 3'd1;
      end else if (|hit_q) begin
        cooldown_d    = CDW'(HIT_CD);
        speed_delay_d = 3'd0;
        if (hit_q[1] || hit_q[0]) speed_d = (speed_q > 10'sd0) ? speed_q + 10'sd4 : 10'sd4;
        else                      speed_d = (speed_q >= 10'sd0) ? -10'sd4 : speed_q - 10'sd4;
      end else if (wall_f_c) begin
        speed_d    = -10'sd3;
        cooldown_d = CDW'(WALL_CD);
      end else begin
        speed_d    = 10'sd3;
        cooldown_d = CDW'(WALL_CD);
      end
    end

    if (state == ST_RACING && !finish_q && inside_c) begin
      if (ckpt_q == CKW'(NUM_CKPT - 1)) begin
        ckpt_d = '0;
        lap_d  = lap_q + LPW'(1);
        if (lap_q == LPW'(NUM_LAPS - 1)) finish_d = 1'b1;
      end else begin
        ckpt_d = ckpt_q + CKW'(1);
      end
    end

    if (state == ST_IDLE) begin
      accum_x_d     = AW'(START_X << FRAC_BITS);
      accum_y_d     = AW'(START_Y << FRAC_BITS);
      speed_d       = 10'sd0;
      angle_d       = 6'd0;
      angle_idx_d   = 4'd0;
      turn_delay_d  = 2'd0;
      speed_delay_d = 3'd0;
      cooldown_d    = '0;
      ckpt_d        = '0;
      lap_d         = '0;
      finish_d      = 1'b0;
      hit_d         = 4'd0;
    end

    pos_x_d = round_pos(accum_x_d);
    pos_y_d = round_pos(accum_y_d);
    f_x_d   = pos_x_q + 10'(dir_x_c >>> 6);
    f_y_d   = pos_y_q + 10'(dir_y_c >>> 6);
    r_x_d   = pos_x_q - 10'(dir_x_c >>> 6);
    r_y_d   = pos_y_q - 10'(dir_y_c >>> 6);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q    <= '0;
      tick_q        <= 1'b0;
      accum_x_q     <= AW'(START_X << FRAC_BITS);
      accum_y_q     <= AW'(START_Y << FRAC_BITS);
      pos_x_q       <= 10'(START_X);
      pos_y_q       <= 10'(START_Y);
      speed_q       <= 10'sd0;
      speed_out_q   <= 10'sd0;
      angle_q       <= 6'd0;
      angle_idx_q   <= 4'd0;
      turn_delay_q  <= 2'd0;
      speed_delay_q <= 3'd0;
      cooldown_q    <= '0;
      ckpt_q        <= '0;
      lap_q         <= '0;
      finish_q      <= 1'b0;
      hit_q         <= 4'd0;
      f_x_q         <= 10'd0;
      f_y_q         <= 10'd0;
      r_x_q         <= 10'd0;
      r_y_q         <= 10'd0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      tick_q        <= tick_d;
      accum_x_q     <= accum_x_d;
      accum_y_q     <= accum_y_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      speed_q       <= speed_d;
      speed_out_q   <= speed_out_d;
      angle_q       <= angle_d;
      angle_idx_q   <= angle_idx_d;
      turn_delay_q  <= turn_delay_d;
      speed_delay_q <= speed_delay_d;
      cooldown_q    <= cooldown_d;
      ckpt_q        <= ckpt_d;
      lap_q         <= lap_d;
      finish_q      <= finish_d;
      hit_q         <= hit_d;
      f_x_q         <= f_x_d;
      f_y_q         <= f_y_d;
      r_x_q         <= r_x_d;
      r_y_q         <= r_y_d;
    end
  end

  assign my_f_x    = f_x_q;
  assign my_f_y    = f_y_q;
  assign my_r_x    = r_x_q;
  assign my_r_y    = r_y_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign angle_idx = angle_idx_q;
  assign speed_out = speed_out_q;
  assign ckpt_idx  = ckpt_q;
  assign lap       = lap_q;
  assign finish    = finish_q;
  assign tick      = tick_q;
endmodule

// File: tb/tb_race_physics_core.sv
// Directed bench for race_physics_core: speed/position scoreboard, steering, collision, checkpoints.
// Honours RPC_BOOST_EN in its expected speeds when the macro is defined.
module tb_race_physics_core;
  localparam int unsigned NCK = 2;
  localparam int unsigned NLP = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           state;
  logic [1:0]           h_code, v_code, color;
  logic [40*NCK-1:0]    ckpt_box;
  logic [9:0]           other_f_x, other_f_y, other_r_x, other_r_y;
  logic [9:0]           my_f_x, my_f_y, my_r_x, my_r_y, pos_x, pos_y;
  logic [3:0]           angle_idx;
  logic signed [9:0]    speed_out;
  logic [1:0]           ckpt_idx;
  logic [0:0]           lap;
  logic                 finish, tick;

  int checks = 0;
  int errors = 0;
  int m_spd, m_sd, m_ay;
  int exp_spd[$];
  int exp_posy[$];
  int exp_ang[$];

  race_physics_core #(
    .START_X(320), .START_Y(240), .CLK_FREQ(1100), .TICK_HZ(100), .NUM_CKPT(NCK), .NUM_LAPS(NLP)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .h_code(h_code), .v_code(v_code), .color(color),
    .ckpt_box(ckpt_box), .other_f_x(other_f_x), .other_f_y(other_f_y),
    .other_r_x(other_r_x), .other_r_y(other_r_y), .my_f_x(my_f_x), .my_f_y(my_f_y),
    .my_r_x(my_r_x), .my_r_y(my_r_y), .pos_x(pos_x), .pos_y(pos_y), .angle_idx(angle_idx),
    .speed_out(speed_out), .ckpt_idx(ckpt_idx), .lap(lap), .finish(finish), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int step_to(input int s, input int lim);
    if (s < lim) return s + 1;
    if (s > lim) return s - 1;
    return s;
  endfunction

  function automatic int round_px(input int a);
    return (a >> 10) + ((a >> 9) & 1);
  endfunction

  // Reference car heading straight up: predicts speed and pos_y after one tick.
  task automatic model_tick(input int v, input int col);
    int lim, tgt;
    bit now;
    lim = 12;
    now = (m_sd == 0);
`ifdef RPC_BOOST_EN
    if (col == 2) begin
      lim = 16;
      if (v == 1) now = 1'b1;
    end
`endif
    tgt = m_spd;
    if (now) tgt = (v == 1) ? step_to(m_spd, lim) : (v == 2) ? step_to(m_spd, -8) : step_to(m_spd, 0);
    if (col == 3) begin
      if (tgt > 6) tgt = 6;
      if (tgt < -4) tgt = -4;
    end
    m_ay  = m_ay + ((m_spd * -256) >>> 2);
    m_spd = tgt;
    m_sd  = (m_sd + 1) % 8;
    exp_spd.push_back(m_spd);
    exp_posy.push_back(round_px(m_ay));
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tick_timeout", 32'(n < 100), 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic drive_tick(input int v, input int col, input string tag);
    int es, ep;
    v_code = 2'(v);
    color  = 2'(col);
    model_tick(v, col);
    wait_tick();
    es = exp_spd.pop_front();
    ep = exp_posy.pop_front();
    chk({tag, "_speed"}, 32'(speed_out), es);
    chk({tag, "_pos_y"}, 32'(pos_y), ep);
  endtask

  task automatic do_reset();
    rst = 1'b1; state = 3'd0; h_code = 2'd0; v_code = 2'd0; color = 2'd0; ckpt_box = '0;
    other_f_x = 10'd600; other_f_y = 10'd400; other_r_x = 10'd600; other_r_y = 10'd400;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_spd = 0; m_sd = 0; m_ay = 240 << 10;
    exp_spd.delete(); exp_posy.delete(); exp_ang.delete();
  endtask

  initial begin
    int n, a, td, p;
    logic [39:0] b;

    rst = 1'b1; state = 3'd0; h_code = 2'd0; v_code = 2'd0; color = 2'd0; ckpt_box = '0;
    other_f_x = 10'd600; other_f_y = 10'd400; other_r_x = 10'd600; other_r_y = 10'd400;
    repeat (3) @(negedge clk);
    chk("rst_pos_x", 32'(pos_x), 320);
    chk("rst_pos_y", 32'(pos_y), 240);
    chk("rst_speed", 32'(speed_out), 0);
    chk("rst_centre", 32'(my_f_x), 0);
    chk("rst_flags", 32'({finish, lap, ckpt_idx, angle_idx}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_f_x", 32'(my_f_x), 320);
    chk("idle_f_y", 32'(my_f_y), 236);
    chk("idle_r_y", 32'(my_r_y), 244);

    // tick period is CLK_FREQ/TICK_HZ + 1 cycles, single-cycle strobe
    n = 0;
    while (tick !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("tick_width", 32'(tick), 0);
    n = 1;
    while (tick !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("tick_period", n, 12);

    // acceleration heading up
    do_reset();
    state = 3'd4;
    for (int i = 0; i < 80; i++) drive_tick(1, 0, "accel");
    chk("accel_final", 32'(speed_out), 10);
    chk("accel_moved_up", 32'(pos_y < 10'd240), 1);
    chk("accel_pos_x", 32'(pos_x), 320);

    // steering right, angle_idx lags internal angle by one tick
    do_reset();
    state = 3'd4; h_code = 2'd2;
    a = 0; td = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 12) h_code = 2'd0;
      exp_ang.push_back(a >> 2);
      if (h_code == 2'd2) begin
        if (td == 0) begin a++; td = 2; end else td--;
      end else td = 0;
      wait_tick();
      chk("steer_angle_idx", 32'(angle_idx), exp_ang.pop_front());
    end
    chk("steer_final_idx", 32'(angle_idx), 1);
    chk("steer_f_x", 32'(my_f_x), 321);
    chk("steer_f_y", 32'(my_f_y), 236);
    chk("steer_r_x", 32'(my_r_x), 319);
    chk("steer_r_y", 32'(my_r_y), 244);

    // slow surface clamps forward and reverse speed
    do_reset();
    state = 3'd4;
    for (int i = 0; i < 64; i++) drive_tick(1, 0, "pre_slow");
    chk("pre_slow_speed", 32'(speed_out), 8);
    drive_tick(1, 3, "slow_fwd");
    chk("slow_fwd_clamp", 32'(speed_out), 6);
    for (int i = 0; i < 200 && m_spd != -8; i++) drive_tick(2, 0, "brake");
    chk("brake_reached", 32'(speed_out), -8);
    drive_tick(2, 3, "slow_rev");
    chk("slow_rev_clamp", 32'(speed_out), -4);

    // car collision: flags sampled on one tick, response on the next
    do_reset();
    state = 3'd4;
    for (int i = 0; i < 33; i++) drive_tick(1, 0, "pre_hit");
    chk("pre_hit_speed", 32'(speed_out), 5);
    p = round_px(m_ay);
    other_f_x = 10'd320; other_f_y = 10'(p - 9);
    other_r_x = 10'd320; other_r_y = 10'(p - 9);
    drive_tick(0, 0, "hit_sample");
    p = round_px(m_ay);
    wait_tick();
    chk("hit_speed", 32'(speed_out), -4);
    chk("hit_frozen_pos", 32'(pos_y), p);
    other_f_x = 10'd600; other_f_y = 10'd400; other_r_x = 10'd600; other_r_y = 10'd400;
    m_spd = -4; m_sd = 0;
    drive_tick(0, 0, "cooldown");

    // checkpoints and finish freeze
    do_reset();
    state = 3'd4;
    for (int i = 0; i < 9; i++) drive_tick(1, 0, "pre_ckpt");
    p = round_px(m_ay);
    b = {10'd310, 10'd330, 10'(p - 30), 10'(p + 10)};
    ckpt_box[39:0] = b;
    @(negedge clk);
    chk("ckpt0_idx", 32'(ckpt_idx), 1);
    chk("ckpt0_lap", 32'(lap), 0);
    ckpt_box[79:40] = b;
    @(negedge clk);
    chk("ckpt1_idx", 32'(ckpt_idx), 0);
    chk("ckpt1_lap", 32'(lap), 1);
    chk("finish_set", 32'(finish), 1);
    for (int i = 0; i < 5; i++) wait_tick();
    chk("finish_hold_pos", 32'(pos_y), p);
    chk("finish_hold_speed", 32'(speed_out), 2);
    chk("finish_sticky", 32'(finish), 1);
    state = 3'd0;
    repeat (2) @(negedge clk);
    chk("idle_clear_finish", 32'(finish), 0);
    chk("idle_clear_lap", 32'(lap), 0);
    chk("idle_pos_y", 32'(pos_y), 240);

    // colour 2: boost surface when enabled, ordinary track otherwise
    do_reset();
    ckpt_box = '0;
    state = 3'd4;
    for (int i = 0; i < 20; i++) drive_tick(1, 2, "boost");
`ifdef RPC_BOOST_EN
    chk("boost_final", 32'(speed_out), 16);
`else
    chk("boost_final", 32'(speed_out), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
